udp_rx_echo_buffer: RTL

UDP_RX_ECHO_BUFFER -- requirements
Module: udp_rx_echo_buffer

---
 rtl/udp_rx_echo_buffer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/udp_rx_echo_buffer.sv
// Receives one UDP payload into a local buffer, validates its length, and echoes
// it back to the UDP transmit stack; packets that cannot be echoed are counted.
module udp_rx_echo_buffer #(
    parameter int          BUF_DEPTH   = 1472,
    parameter int          ADDR_W      = 11,
    parameter logic [31:0] ACK_TIMEOUT = 32'd125_000_000,
    parameter logic [15:0] GAP_CYCLES  = 16'd64
) (
    input  logic        rgmii_clk,
    input  logic        rst,
    input  logic        udp_rec_data_valid,
    input  logic [7:0]  udp_rec_rdata,
    input  logic [15:0] udp_rec_data_length,
    output logic        app_data_request,
    output logic [15:0] app_data_length,
    input  logic        udp_send_ack,
    output logic        app_data_in_valid,
    output logic [7:0]  app_data_in,
    output logic        echo_done,
    output logic [15:0] drop_cnt
);

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_RECV  = 6'b000010,
        S_CHECK = 6'b000100,
        S_REQ   = 6'b001000,
        S_SEND  = 6'b010000,
        S_GAP   = 6'b100000
    } state_t;

    localparam logic [15:0] DEPTH16 = 16'(BUF_DEPTH);

    state_t             r_state, w_next;
    logic               r_vld_d, r_ovf, r_rd_vld, r_echo;
    logic [15:0]        r_wr_cnt, r_len, r_app_len, r_rd_cnt, r_gap, r_drop;
    logic [31:0]        r_tmr;
    logic [7:0]         r_mem [BUF_DEPTH];
    logic [7:0]         r_rd_q;

    logic               w_sop, w_eop, w_wr_en, w_rd_en, w_chk_ok, w_tmo, w_gap_done;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [1:0]         w_drop_inc;
    logic [16:0]        w_drop_sum;

    assign w_sop      = udp_rec_data_valid & ~r_vld_d;
    assign w_eop      = ~udp_rec_data_valid & r_vld_d;
    assign w_tmo      = ({1'b0, r_tmr} + 33'd1) >= {1'b0, ACK_TIMEOUT};
    assign w_gap_done = ({1'b0, r_gap} + 17'd1) >= {1'b0, GAP_CYCLES};
    assign w_drop_sum = {1'b0, r_drop} + {15'd0, w_drop_inc};

    always_ff @(posedge rgmii_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_wr_en    = 1'b0;
        w_wr_addr  = r_wr_cnt[ADDR_W-1:0];
        w_rd_en    = 1'b0;
        w_chk_ok   = 1'b0;
        w_drop_inc = 2'd0;
        case (r_state)
            S_IDLE: if (w_sop) begin
                w_next    = S_RECV;
                w_wr_en   = 1'b1;
                w_wr_addr = '0;
            end
            S_RECV: begin
                if (w_eop)                                          w_next  = S_CHECK;
                else if (udp_rec_data_valid && r_wr_cnt < DEPTH16)  w_wr_en = 1'b1;
            end
            S_CHECK: begin
                w_chk_ok = !r_ovf && (r_wr_cnt == r_len);
                w_next   = w_chk_ok ? S_REQ : S_IDLE;
                if (!w_chk_ok) w_drop_inc = 2'd1;
            end
            S_REQ: begin
                if (udp_send_ack) w_next = S_SEND;
                else if (w_tmo) begin
                    w_next     = S_IDLE;
                    w_drop_inc = 2'd1;
                end
            end
            S_SEND: begin
                if (r_rd_cnt < r_app_len) w_rd_en = 1'b1;
                else                      w_next  = S_GAP;
            end
            S_GAP:   if (w_gap_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // A packet starting while busy is never buffered, only counted.
        if (w_sop && (r_state == S_CHECK || r_state == S_REQ ||
                      r_state == S_SEND  || r_state == S_GAP))
            w_drop_inc = w_drop_inc + 2'd1;
    end

    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            r_vld_d   <= 1'b1;
            r_wr_cnt  <= '0;
            r_ovf     <= 1'b0;
            r_len     <= '0;
            r_app_len <= '0;
            r_tmr     <= '0;
            r_rd_cnt  <= '0;
            r_gap     <= '0;
            r_rd_vld  <= 1'b0;
            r_echo    <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_vld_d  <= udp_rec_data_valid;
            r_rd_vld <= w_rd_en;
            r_echo   <= (r_state == S_SEND) && (w_next == S_GAP);
            r_drop   <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            case (r_state)
                S_IDLE: if (w_sop) begin
                    r_len    <= udp_rec_data_length;
                    r_wr_cnt <= 16'd1;
                    r_ovf    <= 1'b0;
                end
                S_RECV: if (udp_rec_data_valid) begin
                    if (r_wr_cnt < DEPTH16) r_wr_cnt <= r_wr_cnt + 16'd1;
                    else                    r_ovf    <= 1'b1;
                end
                S_CHECK: begin
                    if (w_chk_ok) r_app_len <= r_wr_cnt;
                    r_tmr <= '0;
                end
                S_REQ: begin
                    r_tmr    <= r_tmr + 32'd1;
                    r_rd_cnt <= '0;
                end
                S_SEND: begin
                    if (w_rd_en) r_rd_cnt <= r_rd_cnt + 16'd1;
                    r_gap <= '0;
                end
                S_GAP:   r_gap <= r_gap + 16'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge rgmii_clk) begin
        if (w_wr_en) r_mem[w_wr_addr] <= udp_rec_rdata;
    end

    always_ff @(posedge rgmii_clk) begin
        if (rst)          r_rd_q <= '0;
        else if (w_rd_en) r_rd_q <= r_mem[r_rd_cnt[ADDR_W-1:0]];
    end

    assign app_data_request  = (r_state == S_REQ) || (r_state == S_SEND);
    assign app_data_length   = r_app_len;
    assign app_data_in_valid = r_rd_vld;
    assign app_data_in       = r_rd_q;
    assign echo_done         = r_echo;
    assign drop_cnt          = r_drop;

endmodule
